// File: rtl/udma_ch_cfg_pkg.sv
// Shared constants for the uDMA channel configuration queue: register map,
// CFG field positions, element-size encodings and a saturating counter helper.
package udma_ch_cfg_pkg;

  // Register word indices
  localparam logic [2:0] REG_SADDR  = 3'd0;
  localparam logic [2:0] REG_SIZE   = 3'd1;
  localparam logic [2:0] REG_CFG    = 3'd2;
  localparam logic [2:0] REG_STREAM = 3'd3;
  localparam logic [2:0] REG_DONE   = 3'd4;

  // CFG register bit positions
  localparam int CFG_CONT_BIT   = 0;
  localparam int CFG_DSIZE_LSB  = 1;
  localparam int CFG_EN_BIT     = 4;
  localparam int CFG_CLR_BIT    = 5;
  localparam int CFG_PEND_BIT   = 5;
  localparam int CFG_COUNT_LSB  = 8;
  localparam int CFG_OVF_BIT    = 12;
  localparam int CFG_ERR_BIT    = 13;

  // STREAM register field position of the stream id
  localparam int STREAM_ID_LSB  = 8;

  // Descriptor queue depth (the shift FIFO is written for exactly two entries)
  localparam int QUEUE_DEPTH    = 2;

  // Element size seen by the address generator
  typedef enum logic [1:0] {
    DSIZE_BYTE = 2'd0,
    DSIZE_HALF = 2'd1,
    DSIZE_WORD = 2'd2,
    DSIZE_RSVD = 2'd3
  } datasize_e;

  // Completion counter increment that sticks at its maximum value
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/udma_ch_desc_fifo.sv
// Two-entry shift FIFO holding transfer descriptors. Entry 0 is always the
// head; a pop shifts entry 1 down. A push while full is accepted only when a
// pop happens in the same cycle, otherwise it is dropped.
module udma_ch_desc_fifo
  import udma_ch_cfg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic [1:0]    o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [QUEUE_DEPTH];
  logic [1:0]    r_count;
  logic          w_pop;
  logic          w_push;
  logic          w_wr_idx;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_dout  = r_mem[0];
  assign o_count = r_count;

  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  // Tail slot after any same-cycle pop has been taken into account
  assign w_wr_idx = w_pop ? (r_count == 2'd2) : (r_count != 2'd0);

  // Entry storage and occupancy; clear and reset both empty the queue
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: only two entries, so the storage is reset with the count; this
      // keeps the head-driven outputs at 0 after reset and clear.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_count  <= 2'd0;
    end else if (i_clr) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_count  <= 2'd0;
    end else begin
      if (w_pop) begin
        r_mem[0] <= r_mem[1];
      end
      // NOTE: non-blocking assignments resolve in order, so a push+pop at
      // count 1 writing slot 0 correctly overrides the shift above.
      if (w_push) begin
        r_mem[w_wr_idx] <= i_din;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/udma_ch_cfg_queue.sv
// Register-side configuration stage for one uDMA channel. Software stages a
// descriptor, pushes it into a two-entry queue whose head drives the address
// generator, and reads back status and a saturating completion counter.
module udma_ch_cfg_queue
  import udma_ch_cfg_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL  = 18,
  parameter int TRANS_SIZE      = 16,
  parameter int STREAM_ID_WIDTH = 3,
  parameter int QUEUE_DEPTH_P   = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [31:0]                cfg_data_i,
  input  logic [2:0]                 cfg_addr_i,
  input  logic                       cfg_valid_i,
  input  logic                       cfg_rwn_i,
  output logic [31:0]                cfg_data_o,
  output logic                       cfg_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0]  cfg_startaddr_o,
  output logic [TRANS_SIZE-1:0]      cfg_size_o,
  output logic                       cfg_continuous_o,
  output logic                       cfg_en_o,
  output logic                       cfg_clr_o,
  output logic [1:0]                 cfg_stream_o,
  output logic [STREAM_ID_WIDTH-1:0] cfg_stream_id_o,
  output logic [1:0]                 int_datasize_o,
  input  logic                       int_ch_en_i,
  input  logic                       int_ch_pending_i,
  input  logic                       int_ch_sot_i,
  input  logic                       int_ch_events_i,
  input  logic [L2_AWIDTH_NOAL-1:0]  int_ch_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]      int_ch_bytes_left_i,
  output logic                       evt_o
);

  typedef struct packed {
    logic [L2_AWIDTH_NOAL-1:0]  addr;
    logic [TRANS_SIZE-1:0]      size;
    logic [1:0]                 stream;
    logic [STREAM_ID_WIDTH-1:0] stream_id;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  // Staging and mode registers
  logic [L2_AWIDTH_NOAL-1:0]  r_saddr;
  logic [TRANS_SIZE-1:0]      r_size;
  logic [1:0]                 r_stream;
  logic [STREAM_ID_WIDTH-1:0] r_stream_id;
  logic                       r_continuous;
  datasize_e                  r_datasize;

  // Status registers
  logic        r_clr;
  logic        r_evt;
  logic [7:0]  r_done_cnt;
  logic        r_overflow;
  logic        r_size_err;
  logic [31:0] r_rdata;

  logic        w_wr;
  logic        w_rd;
  logic        w_cfg_wr;
  logic        w_clr;
  logic        w_push_req;
  logic        w_size_zero;
  logic        w_push;
  logic        w_pop;
  logic        w_overflow;
  logic        w_done_rd;
  logic [31:0] w_rdata;
  desc_t       w_din;
  desc_t       w_head;
  logic [1:0]  w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_unused_data;

  assign w_wr        = cfg_valid_i && !cfg_rwn_i;
  assign w_rd        = cfg_valid_i && cfg_rwn_i;
  assign w_cfg_wr    = w_wr && (cfg_addr_i == REG_CFG);
  assign w_clr       = w_cfg_wr && cfg_data_i[CFG_CLR_BIT];
  // Clear wins over an EN carried by the same write
  assign w_push_req  = w_cfg_wr && cfg_data_i[CFG_EN_BIT] && !w_clr;
  assign w_size_zero = (r_size == '0);
  assign w_push      = w_push_req && !w_size_zero;
  // In continuous mode the last descriptor stays at the head for reload
  assign w_pop       = int_ch_sot_i && !w_empty && !(r_continuous && (w_count == 2'd1));
  assign w_overflow  = w_push && w_full && !w_pop;
  assign w_done_rd   = w_rd && (cfg_addr_i == REG_DONE);

  assign w_din = '{addr: r_saddr, size: r_size, stream: r_stream, stream_id: r_stream_id};

  // Upper write-data bits are never decoded by any register
  assign w_unused_data = ^cfg_data_i[31:L2_AWIDTH_NOAL];

  udma_ch_desc_fifo #(
    .DW (DESC_W)
  ) u_desc_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (w_clr),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The access port never stalls, including while reset is asserted
  assign cfg_ready_o      = 1'b1;
  assign cfg_data_o       = r_rdata;
  assign cfg_startaddr_o  = w_head.addr;
  assign cfg_size_o       = w_head.size;
  assign cfg_stream_o     = w_head.stream;
  assign cfg_stream_id_o  = w_head.stream_id;
  assign cfg_en_o         = !w_empty;
  assign cfg_continuous_o = r_continuous;
  assign int_datasize_o   = r_datasize;
  assign cfg_clr_o        = r_clr;
  assign evt_o            = r_evt;

  // Staging registers and the immediate mode fields
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_saddr      <= '0;
      r_size       <= '0;
      r_stream     <= '0;
      r_stream_id  <= '0;
      r_continuous <= 1'b0;
      r_datasize   <= DSIZE_BYTE;
    end else begin
      if (w_clr) begin
        r_saddr     <= '0;
        r_size      <= '0;
        r_stream    <= '0;
        r_stream_id <= '0;
      end else if (w_wr) begin
        unique case (cfg_addr_i)
          REG_SADDR:  r_saddr <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_SIZE:   r_size  <= cfg_data_i[TRANS_SIZE-1:0];
          REG_STREAM: begin
            r_stream    <= cfg_data_i[1:0];
            r_stream_id <= cfg_data_i[STREAM_ID_LSB +: STREAM_ID_WIDTH];
          end
          default: ;
        endcase
      end
      if (w_cfg_wr) begin
        r_continuous <= cfg_data_i[CFG_CONT_BIT];
        r_datasize   <= datasize_e'(cfg_data_i[CFG_DSIZE_LSB +: 2]);
      end
    end
  end

  // Clear pulse, event echo, sticky flags and the completion counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_clr      <= 1'b0;
      r_evt      <= 1'b0;
      r_done_cnt <= 8'd0;
      r_overflow <= 1'b0;
      r_size_err <= 1'b0;
    end else begin
      r_clr <= w_clr;
      r_evt <= int_ch_events_i;
      if (w_push_req && w_size_zero) begin
        r_size_err <= 1'b1;
      end
      if (w_overflow) begin
        r_overflow <= 1'b1;
      end else if (w_done_rd) begin
        r_overflow <= 1'b0;
      end
      if (w_done_rd) begin
        r_done_cnt <= {7'd0, int_ch_events_i};
      end else if (int_ch_events_i) begin
        r_done_cnt <= sat_inc(r_done_cnt);
      end
    end
  end

  // Read-data multiplexer by register index
  always_comb begin
    // NOTE: defaulting the whole word first keeps every path assigned, so no
    // latch is inferred for unused indices or unused bit fields.
    w_rdata = '0;
    unique case (cfg_addr_i)
      REG_SADDR: w_rdata[L2_AWIDTH_NOAL-1:0] = int_ch_curr_addr_i;
      REG_SIZE:  w_rdata[TRANS_SIZE-1:0]     = int_ch_bytes_left_i;
      REG_CFG: begin
        w_rdata[CFG_CONT_BIT]            = r_continuous;
        w_rdata[CFG_DSIZE_LSB +: 2]      = r_datasize;
        w_rdata[CFG_EN_BIT]              = int_ch_en_i;
        w_rdata[CFG_PEND_BIT]            = int_ch_pending_i;
        w_rdata[CFG_COUNT_LSB +: 2]      = w_count;
        w_rdata[CFG_OVF_BIT]             = r_overflow;
        w_rdata[CFG_ERR_BIT]             = r_size_err;
      end
      REG_STREAM: begin
        w_rdata[1:0]                             = r_stream;
        w_rdata[STREAM_ID_LSB +: STREAM_ID_WIDTH] = r_stream_id;
      end
      REG_DONE: begin
        w_rdata[31]  = r_overflow;
        w_rdata[7:0] = r_done_cnt;
      end
      default: ;
    endcase
  end

  // Registered read data, updated only on a read access
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_udma_ch_cfg_queue.sv
// Self-checking bench for udma_ch_cfg_queue: directed scenarios plus a
// randomized push/pop run, all checked against a queue-based reference model.
module tb_udma_ch_cfg_queue;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] cfg_data_i = '0;
  logic [2:0]  cfg_addr_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_rwn_i = 1'b0;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;
  logic [17:0] cfg_startaddr_o;
  logic [15:0] cfg_size_o;
  logic        cfg_continuous_o;
  logic        cfg_en_o;
  logic        cfg_clr_o;
  logic [1:0]  cfg_stream_o;
  logic [2:0]  cfg_stream_id_o;
  logic [1:0]  int_datasize_o;
  logic        int_ch_en_i = 1'b0;
  logic        int_ch_pending_i = 1'b0;
  logic        int_ch_sot_i = 1'b0;
  logic        int_ch_events_i = 1'b0;
  logic [17:0] int_ch_curr_addr_i = '0;
  logic [15:0] int_ch_bytes_left_i = '0;
  logic        evt_o;

  int checks = 0;
  int errors = 0;

  udma_ch_cfg_queue dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .cfg_data_i          (cfg_data_i),
    .cfg_addr_i          (cfg_addr_i),
    .cfg_valid_i         (cfg_valid_i),
    .cfg_rwn_i           (cfg_rwn_i),
    .cfg_data_o          (cfg_data_o),
    .cfg_ready_o         (cfg_ready_o),
    .cfg_startaddr_o     (cfg_startaddr_o),
    .cfg_size_o          (cfg_size_o),
    .cfg_continuous_o    (cfg_continuous_o),
    .cfg_en_o            (cfg_en_o),
    .cfg_clr_o           (cfg_clr_o),
    .cfg_stream_o        (cfg_stream_o),
    .cfg_stream_id_o     (cfg_stream_id_o),
    .int_datasize_o      (int_datasize_o),
    .int_ch_en_i         (int_ch_en_i),
    .int_ch_pending_i    (int_ch_pending_i),
    .int_ch_sot_i        (int_ch_sot_i),
    .int_ch_events_i     (int_ch_events_i),
    .int_ch_curr_addr_i  (int_ch_curr_addr_i),
    .int_ch_bytes_left_i (int_ch_bytes_left_i),
    .evt_o               (evt_o)
  );

  always #5 clk_i = ~clk_i;

  // Watchdog: the run is made of fixed-length sequences, so this only fires
  // if simulation stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [17:0] addr;
    logic [15:0] size;
    logic [1:0]  stream;
    logic [2:0]  sid;
  } mdesc_t;

  mdesc_t      mq[$];
  logic [17:0] m_addr = '0;
  logic [15:0] m_size = '0;
  logic [1:0]  m_stream = '0;
  logic [2:0]  m_sid = '0;
  logic        m_cont = 1'b0;
  logic [1:0]  m_dsize = '0;
  logic        m_ovf = 1'b0;
  logic        m_err = 1'b0;
  int          m_cnt = 0;

  task automatic model_reset();
    mq.delete();
    m_addr = '0; m_size = '0; m_stream = '0; m_sid = '0;
    m_cont = 1'b0; m_dsize = '0; m_ovf = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // One cycle of queue activity: decide the pop from the pre-cycle state,
  // then accept/reject the push, then apply both.
  task automatic model_step(input bit push, input bit sot);
    bit popped;
    bit accept;
    popped = sot && (mq.size() > 0) && !(m_cont && mq.size() == 1);
    accept = 1'b0;
    if (push) begin
      if (m_size == 16'd0) m_err = 1'b1;
      else if (mq.size() == 2 && !popped) m_ovf = 1'b1;
      else accept = 1'b1;
    end
    if (popped) mq.delete(0);
    if (accept) begin
      mdesc_t d;
      d.addr = m_addr; d.size = m_size; d.stream = m_stream; d.sid = m_sid;
      mq.push_back(d);
    end
  endtask

  function automatic logic [31:0] exp_cfg();
    logic [31:0] v;
    v = '0;
    v[0]    = m_cont;
    v[2:1]  = m_dsize;
    v[4]    = int_ch_en_i;
    v[5]    = int_ch_pending_i;
    v[9:8]  = 2'(mq.size());
    v[12]   = m_ovf;
    v[13]   = m_err;
    return v;
  endfunction

  function automatic logic [31:0] exp_done();
    logic [31:0] v;
    v = '0;
    v[31]  = m_ovf;
    v[7:0] = 8'(m_cnt);
    return v;
  endfunction

  // ---------------- bus stimulus (no checking inside) ----------------
  task automatic reg_write(input logic [2:0] a, input logic [31:0] d, input bit sot);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = a; cfg_data_i = d;
    int_ch_sot_i = sot;
    @(negedge clk_i);
    cfg_valid_i = 1'b0; cfg_data_i = '0; int_ch_sot_i = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = a; cfg_data_i = '0;
    @(negedge clk_i);
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0;
    d = cfg_data_o;
  endtask

  task automatic read_done(output logic [31:0] d, output logic [31:0] e);
    reg_read(3'd4, d);
    e = exp_done();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic wr_saddr(input logic [17:0] v);
    reg_write(3'd0, 32'(v), 1'b0); m_addr = v;
  endtask

  task automatic wr_size(input logic [15:0] v);
    reg_write(3'd1, 32'(v), 1'b0); m_size = v;
  endtask

  task automatic wr_stream(input logic [1:0] s, input logic [2:0] id);
    reg_write(3'd3, {21'd0, id, 6'd0, s}, 1'b0); m_stream = s; m_sid = id;
  endtask

  task automatic wr_mode(input logic cont, input logic [1:0] ds);
    reg_write(3'd2, {29'd0, ds, cont}, 1'b0); m_cont = cont; m_dsize = ds;
  endtask

  task automatic do_push(input bit sot);
    reg_write(3'd2, {26'd0, 1'b0, 1'b1, 1'b0, m_dsize, m_cont}, sot);
    model_step(1'b1, sot);
  endtask

  task automatic do_sot();
    @(negedge clk_i); int_ch_sot_i = 1'b1;
    @(negedge clk_i); int_ch_sot_i = 1'b0;
    model_step(1'b0, 1'b1);
  endtask

  task automatic do_clear(input bit with_en);
    reg_write(3'd2, {26'd0, 1'b1, with_en, 4'd0}, 1'b0);
    mq.delete();
    m_addr = '0; m_size = '0; m_stream = '0; m_sid = '0;
    m_cont = 1'b0; m_dsize = '0;
  endtask

  task automatic push_desc(input logic [17:0] a, input logic [15:0] s);
    wr_saddr(a); wr_size(s); do_push(1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({cfg_data_o, cfg_startaddr_o, cfg_size_o, cfg_continuous_o, cfg_en_o, cfg_clr_o,
         cfg_stream_o, cfg_stream_id_o, int_datasize_o, evt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b addr=%h size=%h data=%h exp all 0",
               cfg_en_o, cfg_startaddr_o, cfg_size_o, cfg_data_o);
    end
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready_o);
    end
    rstn_i = 1'b1;
    model_reset();
    @(negedge clk_i);
  endtask

  task automatic test_single_push();
    logic [31:0] rd;
    push_desc(18'h100, 16'h40);
    checks++;
    if (cfg_en_o !== 1'b1 || cfg_startaddr_o !== 18'h100 || cfg_size_o !== 16'h40) begin
      errors++;
      $display("FAIL single_push_head got en=%b addr=%h size=%h exp 1/100/40",
               cfg_en_o, cfg_startaddr_o, cfg_size_o);
    end
    reg_read(3'd2, rd);
    checks++;
    if (rd !== exp_cfg()) begin
      errors++; $display("FAIL single_push_cfg got %h exp %h", rd, exp_cfg());
    end
  endtask

  task automatic test_two_push_pop();
    do_clear(1'b0);
    push_desc(18'h100, 16'h40);
    push_desc(18'h200, 16'h20);
    do_sot();
    checks++;
    if (cfg_en_o !== 1'b1 || cfg_startaddr_o !== 18'h200 || cfg_size_o !== 16'h20 ||
        mq.size() != 1) begin
      errors++;
      $display("FAIL pop_new_head got en=%b addr=%h size=%h exp 1/200/20",
               cfg_en_o, cfg_startaddr_o, cfg_size_o);
    end
    do_sot();
    checks++;
    if (cfg_en_o !== 1'b0) begin
      errors++; $display("FAIL pop_empty got en=%b exp 0", cfg_en_o);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, ex;
    do_clear(1'b0);
    push_desc(18'h100, 16'h40);
    push_desc(18'h200, 16'h20);
    push_desc(18'h300, 16'h10);
    reg_read(3'd2, rd);
    checks++;
    if (rd !== exp_cfg() || rd[12] !== 1'b1) begin
      errors++; $display("FAIL overflow_cfg got %h exp %h", rd, exp_cfg());
    end
    checks++;
    if (cfg_startaddr_o !== 18'h100 || cfg_size_o !== 16'h40) begin
      errors++;
      $display("FAIL overflow_head got addr=%h size=%h exp 100/40", cfg_startaddr_o, cfg_size_o);
    end
    read_done(rd, ex);
    checks++;
    if (rd !== ex || rd[31] !== 1'b1) begin
      errors++; $display("FAIL done_ovf got %h exp %h", rd, ex);
    end
    read_done(rd, ex);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL done_cleared got %h exp %h", rd, 32'h0);
    end
  endtask

  task automatic test_continuous();
    logic [31:0] rd, ex;
    do_clear(1'b0);
    wr_mode(1'b1, 2'd2);
    checks++;
    if (cfg_continuous_o !== 1'b1 || int_datasize_o !== 2'd2) begin
      errors++;
      $display("FAIL mode_immediate got cont=%b ds=%0d exp 1/2", cfg_continuous_o, int_datasize_o);
    end
    push_desc(18'h100, 16'h40);
    repeat (3) do_sot();
    reg_read(3'd2, rd);
    checks++;
    if (rd !== exp_cfg() || cfg_startaddr_o !== 18'h100 || cfg_en_o !== 1'b1) begin
      errors++;
      $display("FAIL cont_reload got cfg=%h addr=%h exp cfg=%h addr=100",
               rd, cfg_startaddr_o, exp_cfg());
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i); int_ch_events_i = 1'b1;
      @(negedge clk_i); int_ch_events_i = 1'b0;
      if (i == 0) begin
        checks++;
        if (evt_o !== 1'b1) begin
          errors++; $display("FAIL evt_echo got %b exp 1", evt_o);
        end
      end
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    read_done(rd, ex);
    checks++;
    if (rd !== ex || rd[7:0] !== 8'd255) begin
      errors++; $display("FAIL done_saturate got %h exp %h", rd, ex);
    end
    wr_mode(1'b0, 2'd0);
  endtask

  task automatic test_size_zero_and_clear();
    logic [31:0] rd;
    do_clear(1'b0);
    wr_size(16'h0);
    do_push(1'b0);
    reg_read(3'd2, rd);
    checks++;
    if (rd !== exp_cfg() || rd[13] !== 1'b1 || rd[9:8] !== 2'd0) begin
      errors++; $display("FAIL size_zero got %h exp %h", rd, exp_cfg());
    end
    push_desc(18'h111, 16'h11);
    push_desc(18'h222, 16'h22);
    do_clear(1'b1);
    checks++;
    if (cfg_clr_o !== 1'b1 || cfg_en_o !== 1'b0) begin
      errors++; $display("FAIL clr_pulse got clr=%b en=%b exp 1/0", cfg_clr_o, cfg_en_o);
    end
    @(negedge clk_i);
    checks++;
    if (cfg_clr_o !== 1'b0) begin
      errors++; $display("FAIL clr_width got %b exp 0", cfg_clr_o);
    end
    reg_read(3'd2, rd);
    checks++;
    if (rd !== exp_cfg()) begin
      errors++; $display("FAIL clr_count got %h exp %h", rd, exp_cfg());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    do_clear(1'b0);
    push_desc(18'h100, 16'h40);
    push_desc(18'h200, 16'h20);
    wr_saddr(18'h300); wr_size(16'h10);
    do_push(1'b1);
    reg_read(3'd2, rd);
    checks++;
    if (rd[9:8] !== 2'd2 || rd !== exp_cfg() || cfg_startaddr_o !== 18'h200 ||
        cfg_size_o !== 16'h20) begin
      errors++;
      $display("FAIL push_pop_full got cfg=%h addr=%h exp cfg=%h addr=200",
               rd, cfg_startaddr_o, exp_cfg());
    end
    do_sot();
    checks++;
    if (cfg_startaddr_o !== 18'h300 || cfg_size_o !== 16'h10) begin
      errors++;
      $display("FAIL push_pop_tail got addr=%h size=%h exp 300/10", cfg_startaddr_o, cfg_size_o);
    end
  endtask

  task automatic test_stream_and_readback();
    logic [31:0] rd;
    do_clear(1'b0);
    wr_stream(2'd2, 3'd5);
    reg_read(3'd3, rd);
    checks++;
    if (rd !== 32'h0000_0502) begin
      errors++; $display("FAIL stream_read got %h exp %h", rd, 32'h0000_0502);
    end
    push_desc(18'h044, 16'h8);
    checks++;
    if (cfg_stream_o !== mq[0].stream || cfg_stream_id_o !== mq[0].sid) begin
      errors++;
      $display("FAIL stream_head got %0d/%0d exp %0d/%0d",
               cfg_stream_o, cfg_stream_id_o, mq[0].stream, mq[0].sid);
    end
    int_ch_curr_addr_i  = 18'($urandom);
    int_ch_bytes_left_i = 16'($urandom);
    int_ch_en_i = 1'b1; int_ch_pending_i = 1'b1;
    reg_read(3'd0, rd);
    checks++;
    if (rd !== 32'(int_ch_curr_addr_i)) begin
      errors++; $display("FAIL saddr_read got %h exp %h", rd, 32'(int_ch_curr_addr_i));
    end
    reg_read(3'd1, rd);
    checks++;
    if (rd !== 32'(int_ch_bytes_left_i)) begin
      errors++; $display("FAIL size_read got %h exp %h", rd, 32'(int_ch_bytes_left_i));
    end
    reg_read(3'd2, rd);
    checks++;
    if (rd !== exp_cfg()) begin
      errors++; $display("FAIL cfg_status got %h exp %h", rd, exp_cfg());
    end
    reg_read(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL unused_read got %h exp 0", rd);
    end
    int_ch_en_i = 1'b0; int_ch_pending_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    do_clear(1'b0);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: wr_saddr(18'($urandom));
        1: wr_size(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF)));
        2: do_push(1'b0);
        3: do_sot();
        default: do_push(1'b1);
      endcase
      checks++;
      if (cfg_en_o !== (mq.size() != 0) ||
          (mq.size() != 0 && (cfg_startaddr_o !== mq[0].addr || cfg_size_o !== mq[0].size))) begin
        errors++;
        $display("FAIL random_head it=%0d got en=%b addr=%h size=%h exp n=%0d",
                 i, cfg_en_o, cfg_startaddr_o, cfg_size_o, mq.size());
      end
      if (i % 25 == 24) begin
        reg_read(3'd2, rd);
        checks++;
        if (rd !== exp_cfg()) begin
          errors++; $display("FAIL random_cfg it=%0d got %h exp %h", i, rd, exp_cfg());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    do_clear(1'b0);
    wr_stream(2'd3, 3'd7);
    wr_mode(1'b1, 2'd3);
    push_desc(18'h3AB, 16'h77);
    push_desc(18'h155, 16'h33);
    reg_read(3'd3, rd);
    @(negedge clk_i);
    int_ch_events_i = 1'b1;
    @(posedge clk_i);
    #3 rstn_i = 1'b0;
    #1;
    checks++;
    if ({cfg_data_o, cfg_startaddr_o, cfg_size_o, cfg_continuous_o, cfg_en_o, cfg_clr_o,
         cfg_stream_o, cfg_stream_id_o, int_datasize_o, evt_o} !== '0) begin
      errors++;
      $display("FAIL async_reset got en=%b addr=%h cont=%b evt=%b data=%h exp all 0",
               cfg_en_o, cfg_startaddr_o, cfg_continuous_o, evt_o, cfg_data_o);
    end
    int_ch_events_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    model_reset();
    reg_read(3'd2, rd);
    checks++;
    if (rd !== exp_cfg()) begin
      errors++; $display("FAIL post_reset_cfg got %h exp %h", rd, exp_cfg());
    end
    reg_read(3'd4, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL post_reset_done got %h exp 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_two_push_pop();
    test_overflow();
    test_continuous();
    test_size_zero_and_clear();
    test_back_to_back();
    test_stream_and_readback();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
